// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between the I-side line
// refill path and the D-side refill/writeback path. Each grant runs a whole
// BURST-word line, one beat per accepted memory handshake.
//
// Optional build macro: MEM_ARB_RR_EN
//   undefined -> fixed priority, D side wins a tie in IDLE.
//   defined   -> a last_owner register hands a tie to the side that did not
//                own the previous burst; a lone requester is still granted
//                immediately.
module mem_port_arbiter #(
    parameter int BURST = 4,
    parameter int BW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    // I side
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    output logic          i_done,
    // D side
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_done,
    // status
    output logic [BW-1:0] beat_idx,
    output logic          gnt_d,
    // memory port
    output logic          mem_req,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

    state_t        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [31:0]   base_q, base_d;
    logic          we_q, we_d;
    logic          busy;
    logic          fire;
    logic          last_beat;
    logic          d_wins;

    // Line addresses are word aligned; the byte-offset bits carry no meaning.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    assign busy      = (state_q != IDLE);
    assign fire      = busy & mem_ready;
    assign last_beat = (beat_q == LAST_BEAT);

`ifdef MEM_ARB_RR_EN
    // 0 = I side owned the previous burst, 1 = D side.
    logic last_owner_q, last_owner_d;

    // Remember who was granted last so the next tie goes the other way.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner_q <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`endif

    // State, beat counter and latched burst parameters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            we_q    <= we_d;
        end
    end

    // Next-state: arbitrate in IDLE, advance beats on each accepted handshake.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        we_d    = we_q;
`ifdef MEM_ARB_RR_EN
        last_owner_d = last_owner_q;
        d_wins       = d_req & (~i_req | ~last_owner_q);
`else
        d_wins       = d_req;
`endif
        unique case (state_q)
            IDLE: begin
                beat_d = '0;
                if (d_wins) begin
                    state_d = D_BUSY;
                    base_d  = {d_addr[31:2], 2'b00};
                    we_d    = d_we;
`ifdef MEM_ARB_RR_EN
                    last_owner_d = 1'b1;
`endif
                end else if (i_req) begin
                    state_d = I_BUSY;
                    base_d  = {i_addr[31:2], 2'b00};
                    we_d    = 1'b0;
`ifdef MEM_ARB_RR_EN
                    last_owner_d = 1'b0;
`endif
                end
            end
            I_BUSY, D_BUSY: begin
                if (fire) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Beat outputs: only the owner's signals move; everything else stays 0.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        gnt_d     = 1'b0;
        i_rvalid  = 1'b0;
        i_rdata   = '0;
        i_done    = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        d_done    = 1'b0;
        beat_idx  = beat_q;
        if (busy) begin
            mem_req  = 1'b1;
            mem_addr = base_q + (32'(beat_q) << 2);
            if (state_q == D_BUSY) begin
                gnt_d     = 1'b1;
                mem_we    = we_q;
                mem_wdata = d_wdata;
                if (fire) begin
                    if (!we_q) begin
                        d_rvalid = 1'b1;
                        d_rdata  = mem_rdata;
                    end
                    d_done = last_beat;
                end
            end else if (fire) begin
                i_rvalid = 1'b1;
                i_rdata  = mem_rdata;
                i_done   = last_beat;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Each burst is predicted from the
// line-level rules: owner chosen by the arbitration model, beat k at
// base + 4*k, read data from a fixed address-derived memory image.
module tb_mem_port_arbiter;

    localparam int BURST = 4;
    localparam int BW    = 2;
    localparam logic [31:0] KEY = 32'h5A5A_C3C3;

    logic          clk;
    logic          reset;
    logic          i_req;
    logic [31:0]   i_addr;
    logic          i_rvalid;
    logic [31:0]   i_rdata;
    logic          i_done;
    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          d_done;
    logic [BW-1:0] beat_idx;
    logic          gnt_d;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [31:0]   mem_rdata;

    int checks = 0;
    int errors = 0;
    bit last_d = 1'b0;

    mem_port_arbiter #(.BURST(BURST), .BW(BW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .beat_idx(beat_idx), .gnt_d(gnt_d),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // Memory image: every word reads back as its address xor a key.
    assign mem_rdata = mem_addr ^ KEY;

    logic [6:0] ctrl;
    assign ctrl = {mem_req, gnt_d, mem_we, i_rvalid, i_done, d_rvalid, d_done};

    logic [135+BW-1:0] all_out;
    assign all_out = {i_rvalid, i_rdata, i_done, d_rvalid, d_rdata, d_done, beat_idx,
                      gnt_d, mem_req, mem_we, mem_addr, mem_wdata};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arbitration rule: D wins unless round-robin hands a tie to I.
    function automatic bit model_pick_d(input bit ir, input bit dr);
`ifdef MEM_ARB_RR_EN
        return dr && (!ir || !last_d);
`else
        return dr;
`endif
    endfunction

    // Drive requests for one IDLE cycle, confirm the port is idle, report the expected winner.
    task automatic request(input bit ir, input bit dr, input logic [31:0] ia,
                           input logic [31:0] da, input bit we, input string tag,
                           output bit pick);
        @(negedge clk);
        i_req = ir; d_req = dr; i_addr = ia; d_addr = da; d_we = we;
        mem_ready = 1'($urandom % 2);
        #1;
        checks++;
        if ({ctrl, beat_idx} !== '0) begin
            errors++;
            $display("FAIL %s idle: ctrl=%b beat=%0d required ctrl=0 beat=0", tag, ctrl, beat_idx);
        end
        pick = model_pick_d(ir, dr);
        if (ir || dr) last_d = pick;
    endtask

    // Run one granted burst; mode 0 ready always, 1 toggling, 2 random.
    task automatic drive_burst(input bit is_d, input bit we, input logic [31:0] base,
                               input int mode, input int drop_after, input bit raise_other,
                               input string tag);
        int k = 0;
        int cyc = 0;
        bit rdy;
        logic [31:0] ea, exp_ir, exp_dr, exp_wd;
        logic [6:0] exp_ctrl;
        while (k < BURST && cyc < 200) begin
            @(negedge clk);
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
            mem_ready = rdy;
            d_wdata = $urandom;
            if (is_d) d_addr = $urandom; else i_addr = $urandom;
            if (raise_other && k >= 1) begin
                if (is_d) i_req = 1'b1; else d_req = 1'b1;
            end
            #1;
            ea = base + 32'(4 * k);
            exp_ctrl = {1'b1, is_d, is_d && we,
                        !is_d && rdy, !is_d && rdy && (k == BURST - 1),
                        is_d && rdy && !we, is_d && rdy && (k == BURST - 1)};
            exp_ir = (!is_d && rdy) ? (ea ^ KEY) : 32'h0;
            exp_dr = (is_d && rdy && !we) ? (ea ^ KEY) : 32'h0;
            exp_wd = is_d ? d_wdata : 32'h0;
            checks++;
            if (ctrl !== exp_ctrl) begin
                errors++;
                $display("FAIL %s ctrl beat %0d: got %b required %b", tag, k, ctrl, exp_ctrl);
            end
            checks++;
            if (mem_addr !== ea) begin
                errors++;
                $display("FAIL %s addr beat %0d: got %h required %h", tag, k, mem_addr, ea);
            end
            checks++;
            if (beat_idx !== BW'(k)) begin
                errors++;
                $display("FAIL %s beat_idx: got %0d required %0d", tag, beat_idx, k);
            end
            checks++;
            if (mem_wdata !== exp_wd) begin
                errors++;
                $display("FAIL %s wdata beat %0d: got %h required %h", tag, k, mem_wdata, exp_wd);
            end
            checks++;
            if (i_rdata !== exp_ir || d_rdata !== exp_dr) begin
                errors++;
                $display("FAIL %s rdata beat %0d: got i=%h d=%h required i=%h d=%h",
                         tag, k, i_rdata, d_rdata, exp_ir, exp_dr);
            end
            if (rdy) begin
                if (drop_after >= 0 && k == drop_after) begin
                    if (is_d) d_req = 1'b0; else i_req = 1'b0;
                end
                k++;
            end
            cyc++;
        end
        checks++;
        if (k != BURST) begin
            errors++;
            $display("FAIL %s timeout: beats seen %0d required %0d", tag, k, BURST);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        i_addr = 32'h1234_5678; d_addr = 32'h8765_4320; d_wdata = 32'hFFFF_FFFF; mem_ready = 1'b1;
        #3;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_out: got %h required 0", all_out);
        end
        @(negedge clk); #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_held: got %h required 0", all_out);
        end
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        reset = 1'b1;
        last_d = 1'b0;
    endtask

    task automatic test_i_read();
        bit p;
        request(1, 0, 32'h0000_1000, 32'h0, 0, "iread_req", p);
        drive_burst(p, 1'b0, 32'h0000_1000, 0, -1, 1'b0, "iread");
        request(0, 0, 32'h0, 32'h0, 0, "iread_after", p);
    endtask

    task automatic test_d_writeback();
        bit p;
        request(0, 1, 32'h0, 32'h0000_2000, 1, "dwb_req", p);
        drive_burst(p, 1'b1, 32'h0000_2000, 1, -1, 1'b0, "dwb");
        request(0, 0, 32'h0, 32'h0, 0, "dwb_after", p);
    endtask

    task automatic test_tie();
        bit p;
        request(1, 1, 32'h0000_3000, 32'h0000_4000, 0, "tie1_req", p);
        drive_burst(p, 1'b0, p ? 32'h0000_4000 : 32'h0000_3000, 2, -1, 1'b0, "tie1");
        request(1, 1, 32'h0000_3000, 32'h0000_4040, 0, "tie2_req", p);
        drive_burst(p, 1'b0, p ? 32'h0000_4040 : 32'h0000_3000, 2, -1, 1'b0, "tie2");
        request(1, 0, 32'h0000_3000, 32'h0, 0, "tie3_req", p);
        drive_burst(p, 1'b0, 32'h0000_3000, 2, -1, 1'b0, "tie3");
    endtask

    task automatic test_drop_req();
        bit p;
        request(1, 0, 32'h0000_1100, 32'h0000_5000, 0, "drop_req", p);
        drive_burst(p, 1'b0, 32'h0000_1100, 0, 1, 1'b1, "drop");
        request(0, 1, 32'h0, 32'h0000_5000, 0, "late_d_req", p);
        drive_burst(p, 1'b0, 32'h0000_5000, 0, -1, 1'b0, "late_d");
    endtask

    task automatic test_reset_mid_burst();
        bit p;
        request(0, 1, 32'h0, 32'h0000_6000, 0, "rst_req", p);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            #1;
            checks++;
            if (beat_idx !== BW'(k) || gnt_d !== 1'b1) begin
                errors++;
                $display("FAIL rst_pre beat: got beat=%0d gnt_d=%b required beat=%0d gnt_d=1",
                         beat_idx, gnt_d, k);
            end
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL rst_async: got %h required 0", all_out);
        end
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL rst_low: got %h required 0", all_out);
        end
        reset = 1'b1;
        last_d = 1'b0;
        p = model_pick_d(1'b0, 1'b1);
        last_d = p;
        drive_burst(p, 1'b0, 32'h0000_6000, 2, -1, 1'b0, "rst_fresh");
    endtask

    task automatic test_wrap();
        bit p;
        request(1, 0, 32'hFFFF_FFF8, 32'h0, 0, "wrap_req", p);
        drive_burst(p, 1'b0, 32'hFFFF_FFF8, 2, -1, 1'b0, "wrap");
    endtask

    task automatic test_random();
        bit p, ir, dr, we;
        logic [31:0] ia, da;
        for (int n = 0; n < 40; n++) begin
            ir = 1'($urandom % 2);
            dr = 1'($urandom % 2);
            we = 1'($urandom % 2);
            ia = $urandom;
            da = $urandom;
            request(ir, dr, ia, da, we, "rand_req", p);
            if (ir || dr) begin
                drive_burst(p, p ? we : 1'b0, (p ? da : ia) & 32'hFFFF_FFFC, 2, -1, 1'b0, "rand");
            end
        end
        request(0, 0, 32'h0, 32'h0, 0, "rand_end", p);
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_writeback();
        test_tie();
        test_drop_req();
        test_reset_mid_burst();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
